// File: rtl/jamma_joy_scanner.sv
// JAMMA control scanner: drives the player select line, samples and debounces each
// player's byte from the shared JJOY bus, and synchronises/stretches the coin switches.

module jjs_debounce #(
    parameter int DB_SAMPLES = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       smp,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [3:0] CNT_MAX = 4'(DB_SAMPLES - 1);

    logic [7:0] cand;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    // cnt holds (run length - 1) of the current candidate, saturating at CNT_MAX;
    // the output loads on the sample that completes a run of DB_SAMPLES.
    always_comb begin
        cnt_nxt = '0;
        if (din == cand)
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cand <= 8'hFF;
            cnt  <= '0;
            dout <= 8'hFF;
        end else if (smp) begin
            cand <= din;
            cnt  <= cnt_nxt;
            if (cnt_nxt == CNT_MAX)
                dout <= din;
        end
    end
endmodule

module jjs_coin #(
    parameter int COIN_STRETCH = 4095
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic din,
    output logic dout
);
    localparam logic [15:0] LOAD = 16'(COIN_STRETCH);

    logic        s1;
    logic        s2;
    logic        prev;
    logic [15:0] cnt;

    // Synchroniser runs on every clk; the edge detector only moves on ce so a
    // press is seen once per strobe regardless of how long the switch is held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
            cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (ce) begin
                prev <= s2;
                if (prev && !s2)
                    cnt <= LOAD;
                else if (cnt != '0)
                    cnt <= cnt - 16'd1;
            end
        end
    end

    assign dout = (cnt == '0);
endmodule

module jamma_joy_scanner #(
    parameter int SETTLE       = 7,
    parameter int DB_SAMPLES   = 3,
    parameter int COIN_STRETCH = 4095
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [7:0] jjoy,
    input  logic [1:0] jcoin,
    output logic       jselect,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic [1:0] coin,
    output logic       scan_done
);
    localparam int         NUM_LANES   = 2;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        SETTLE_P1,
        SAMPLE_P1,
        SETTLE_P2,
        SAMPLE_P2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] settle_cnt;
    logic [7:0] settle_cnt_nxt;
    logic       jsel_nxt;

    logic [NUM_LANES-1:0]       smp;
    logic [NUM_LANES-1:0][7:0]  joy_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= SETTLE_P1;
            settle_cnt <= '0;
            jselect    <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            jselect    <= jsel_nxt;
            scan_done  <= ce && (state == SAMPLE_P2);
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        jsel_nxt       = jselect;
        if (ce) begin
            unique case (state)
                SETTLE_P1, SETTLE_P2: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt_nxt = '0;
                        state_nxt      = (state == SETTLE_P1) ? SAMPLE_P1 : SAMPLE_P2;
                    end else begin
                        settle_cnt_nxt = settle_cnt + 8'd1;
                    end
                end
                SAMPLE_P1: begin
                    jsel_nxt  = 1'b1;
                    state_nxt = SETTLE_P2;
                end
                SAMPLE_P2: begin
                    jsel_nxt  = 1'b0;
                    state_nxt = SETTLE_P1;
                end
                default: state_nxt = SETTLE_P1;
            endcase
        end
    end

    assign smp[0] = ce && (state == SAMPLE_P1);
    assign smp[1] = ce && (state == SAMPLE_P2);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        jjs_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .smp    (smp[i]),
            .din    (jjoy),
            .dout   (joy_q[i])
        );

        jjs_coin #(.COIN_STRETCH(COIN_STRETCH)) u_coin (
            .clk    (clk),
            .reset_n(reset_n),
            .ce     (ce),
            .din    (jcoin[i]),
            .dout   (coin[i])
        );
    end

    assign joy1 = joy_q[0];
    assign joy2 = joy_q[1];
endmodule
